pwm_actuator: RTL and testbench

Output stage of the servo loop. Takes the signed controller command from the PID block, saturates it, and converts it into a two-leg (H-bridge) PWM drive with direction and dead time. It also generates the periodic sample strobe that drives the PID `enable`. This makes it the timing master and the consuming end of the controller interface.

---
 rtl/pwm_actuator.sv | 132 +++++++++++++
 tb/tb_pwm_actuator.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pwm_actuator.sv
// H-bridge PWM output stage: saturates the signed PID command, drives one leg per
// direction with reversal dead time, and issues the periodic PID sample strobe.
module pwm_actuator #(
    parameter int Width     = 18,
    parameter int CntWidth  = 10,
    parameter int Period    = 1000,
    parameter int DeadTime  = 8,
    parameter int SampleDiv = 10
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic [Width-1:0] u,
    input  logic             out_en,
    output logic             sample_en,
    output logic             pwm_a,
    output logic             pwm_b,
    output logic             sat,
    output logic             dir
);

    localparam int MagW = Width + 1;
    localparam int DivW = (SampleDiv > 1) ? $clog2(SampleDiv) : 1;

    localparam logic [CntWidth-1:0] PeriodC  = CntWidth'(Period);
    localparam logic [CntWidth-1:0] PeriodM1 = CntWidth'(Period - 1);
    localparam logic [CntWidth-1:0] HalfC    = CntWidth'(Period / 2);
    localparam logic [CntWidth-1:0] DeadC    = CntWidth'(DeadTime);
    localparam logic [MagW-1:0]     PeriodW  = MagW'(Period);
    localparam logic [DivW-1:0]     DivM1    = DivW'(SampleDiv - 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [DivW-1:0]     div_q, div_d;
    logic [CntWidth-1:0] duty_q, duty_d;
    logic                dir_q, dir_d;
    logic                chg_q, chg_d;
    logic                sat_q, sat_d;
    logic                pwm_a_q, pwm_a_d;
    logic                pwm_b_q, pwm_b_d;
    logic                sample_q, sample_d;

    logic                wrap_s;
    logic [MagW-1:0]     u_ext_s;
    logic [MagW-1:0]     mag_s;
    logic                clip_s;
    logic [CntWidth-1:0] lo_s;
    logic                act_s;

    // Next-state: counters, command latch and the output pattern for the coming phase
    always_comb begin
        wrap_s  = (cnt_q == PeriodM1);
        // Magnitude at Width+1 bits so the most negative command negates cleanly
        u_ext_s = {u[Width-1], u};
        if (u[Width-1]) begin
            mag_s = ~u_ext_s + {{(MagW-1){1'b0}}, 1'b1};
        end else begin
            mag_s = u_ext_s;
        end
        clip_s = (mag_s > PeriodW);

        if (wrap_s) begin
            cnt_d = '0;
            if (div_q == DivM1) begin
                div_d = '0;
            end else begin
                div_d = div_q + {{(DivW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
            div_d = div_q;
        end

        duty_d = duty_q;
        dir_d  = dir_q;
        chg_d  = chg_q;
        sat_d  = sat_q;
        if (!out_en) begin
            duty_d = '0;
            if (wrap_s) begin
                chg_d = 1'b0;
                sat_d = 1'b0;
            end else begin
                chg_d = chg_q;
                sat_d = sat_q;
            end
        end else if (wrap_s) begin
            duty_d = clip_s ? PeriodC : mag_s[CntWidth-1:0];
            sat_d  = clip_s;
            dir_d  = u[Width-1];
            chg_d  = (u[Width-1] != dir_q) && (duty_q != '0);
        end else begin
            duty_d = duty_q;
        end

        lo_s     = chg_d ? DeadC : '0;
        act_s    = (cnt_d >= lo_s) && (cnt_d < duty_d);
        pwm_a_d  = act_s && !dir_d;
        pwm_b_d  = act_s && dir_d;
        sample_d = (cnt_d == HalfC) && (div_d == DivM1);
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge sclk) begin
        if (rst) begin
            cnt_q    <= '0;
            div_q    <= '0;
            duty_q   <= '0;
            dir_q    <= 1'b0;
            chg_q    <= 1'b0;
            sat_q    <= 1'b0;
            pwm_a_q  <= 1'b0;
            pwm_b_q  <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            duty_q   <= duty_d;
            dir_q    <= dir_d;
            chg_q    <= chg_d;
            sat_q    <= sat_d;
            pwm_a_q  <= pwm_a_d;
            pwm_b_q  <= pwm_b_d;
            sample_q <= sample_d;
        end
    end

    assign pwm_a     = pwm_a_q;
    assign pwm_b     = pwm_b_q;
    assign sat       = sat_q;
    assign dir       = dir_q;
    assign sample_en = sample_q;

endmodule

// File: tb/tb_pwm_actuator.sv
// Scoreboard bench for pwm_actuator: stimulus pushes hand-derived per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pwm_actuator;

    logic               sclk = 1'b0;
    logic               rst;
    logic signed [17:0] u;
    logic               out_en;
    logic               sample_en;
    logic               pwm_a;
    logic               pwm_b;
    logic               sat;
    logic               dir;

    int checks   = 0;
    int failures = 0;
    int pidx     = 0;
    int step     = 0;
    bit mon_on   = 1'b0;

    typedef struct packed {
        logic a;
        logic b;
        logic sat;
        logic dir;
        logic se;
        int   step;
        int   ph;
    } exp_t;

    exp_t sb_q[$];

    pwm_actuator #(
        .Width(18), .CntWidth(10), .Period(100), .DeadTime(4), .SampleDiv(2)
    ) dut (
        .sclk(sclk), .rst(rst), .u(u), .out_en(out_en), .sample_en(sample_en),
        .pwm_a(pwm_a), .pwm_b(pwm_b), .sat(sat), .dir(dir)
    );

    always #5 sclk = ~sclk;

    // Monitor: one expected record per cycle, plus the leg-exclusion check
    always @(negedge sclk) begin
        if (mon_on) begin
            checks++;
            if (pwm_a === 1'b1 && pwm_b === 1'b1) begin
                failures++;
                $display("FAIL both_legs step%0d: pwm_a=%b pwm_b=%b required not both 1", step, pwm_a, pwm_b);
            end
        end
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if ({pwm_a, pwm_b, sat, dir, sample_en} !== {e.a, e.b, e.sat, e.dir, e.se}) begin
                failures++;
                $display("FAIL out step%0d ph%0d: got a=%b b=%b sat=%b dir=%b se=%b required a=%b b=%b sat=%b dir=%b se=%b",
                         e.step, e.ph, pwm_a, pwm_b, sat, dir, sample_en, e.a, e.b, e.sat, e.dir, e.se);
            end
        end
    end

    // One period (or ncyc cycles of it): expected outputs for this period, command for the next latch
    task automatic run_period(input int a_lo, input int a_hi, input int b_lo, input int b_hi,
                              input logic es, input logic ed, input logic signed [17:0] nu,
                              input int off_at, input int on_at, input int ncyc, input int rst_at);
        for (int k = 0; k < ncyc; k++) begin
            exp_t e;
            e.a    = (k >= a_lo) && (k < a_hi);
            e.b    = (k >= b_lo) && (k < b_hi);
            e.sat  = es;
            e.dir  = ed;
            e.se   = (k == 50) && (pidx % 2 == 1);
            e.step = step;
            e.ph   = k;
            sb_q.push_back(e);
            u      = nu;
            out_en = !((k >= off_at) && (k < on_at));
            rst    = (k == rst_at);
            @(posedge sclk);
            #1;
        end
        rst = 1'b0;
        if (rst_at >= 0) begin
            pidx = 0;
        end else begin
            pidx = pidx + 1;
        end
        step++;
    endtask

    initial begin
        exp_t z;
        rst    = 1'b1;
        out_en = 1'b0;
        u      = 18'sd0;
        @(posedge sclk);
        #1;
        mon_on = 1'b1;
        z = '{a: 1'b0, b: 1'b0, sat: 1'b0, dir: 1'b0, se: 1'b0, step: 99, ph: 0};
        sb_q.push_back(z);
        @(posedge sclk);
        #1;
        rst = 1'b0;

        run_period(0, 0,  0, 0,   1'b0, 1'b0,  18'sd30,   100, 100, 100, -1);
        run_period(0, 30, 0, 0,   1'b0, 1'b0,  18'sd30,   100, 100, 100, -1);
        run_period(0, 30, 0, 0,   1'b0, 1'b0, -18'sd250,  100, 100, 100, -1);
        run_period(0, 0,  4, 100, 1'b1, 1'b1, -18'sd250,  100, 100, 100, -1);
        run_period(0, 0,  0, 100, 1'b1, 1'b1,  18'sh20000, 100, 100, 100, -1);
        run_period(0, 0,  0, 100, 1'b1, 1'b1,  18'sd0,    100, 100, 100, -1);
        run_period(0, 0,  0, 0,   1'b0, 1'b0,  18'sd50,   100, 100, 100, -1);
        run_period(0, 50, 0, 0,   1'b0, 1'b0,  18'sd50,   100, 100, 100, -1);
        run_period(0, 50, 0, 0,   1'b0, 1'b0,  18'sd80,   100, 100, 100, -1);
        run_period(0, 80, 0, 0,   1'b0, 1'b0,  18'sd80,   100, 100, 100, -1);
        // out_en low for phases 10..59: leg drops after phase 10, no resumption mid-period
        run_period(0, 11, 0, 0,   1'b0, 1'b0,  18'sd80,   10,  60,  100, -1);
        run_period(0, 80, 0, 0,   1'b0, 1'b0,  18'sd80,   100, 100, 100, -1);
        // Reset sampled at the end of phase 40
        run_period(0, 80, 0, 0,   1'b0, 1'b0,  18'sd80,   100, 100, 41,  40);
        run_period(0, 0,  0, 0,   1'b0, 1'b0,  18'sd80,   100, 100, 100, -1);
        run_period(0, 80, 0, 0,   1'b0, 1'b0,  18'sd80,   100, 100, 100, -1);
        run_period(0, 80, 0, 0,   1'b0, 1'b0,  18'sd80,   100, 100, 100, -1);

        @(negedge sclk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d records left, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
